// File: rtl/doa_pkg.sv
// Shared types and width helpers for the DOA band collector.
package doa_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_SEND  = 2'd2
    } rd_state_e;

    function automatic int band_w(input int bands);
        return (bands > 1) ? $clog2(bands) : 1;
    endfunction

    // Entry layout, MSB first: {y, x, lmax, lmin, error}
    function automatic int entry_w(input int din_w);
        return 4 * din_w + 1;
    endfunction

endpackage

// File: rtl/doa_pingpong_ram.sv
// Two-bank entry store: one write port, one read port, registered read data.
module doa_pingpong_ram
    import doa_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int WIDTH  = 65
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The read register doubles as the output data register, so it is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/doa_band_collector.sv
// Collects per-band eigen results into double-buffered frames and streams
// each completed frame out in band order over valid/ready/last.
module doa_band_collector
    import doa_pkg::*;
#(
    parameter int DIN_WIDTH     = 16,
    parameter int BANDS         = 4,
    parameter int OVF_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DIN_WIDTH-1:0] lamb1_i,
    input  logic signed [DIN_WIDTH-1:0] lamb2_i,
    input  logic signed [DIN_WIDTH-1:0] eigen1_y_i,
    input  logic signed [DIN_WIDTH-1:0] eigen2_y_i,
    input  logic signed [DIN_WIDTH-1:0] eigen_x_i,
    input  logic                        din_valid_i,
    input  logic                        din_error_i,
    input  logic [band_w(BANDS)-1:0]    band_in_i,
    output logic signed [DIN_WIDTH-1:0] dout_y_o,
    output logic signed [DIN_WIDTH-1:0] dout_x_o,
    output logic signed [DIN_WIDTH-1:0] dout_lmax_o,
    output logic signed [DIN_WIDTH-1:0] dout_lmin_o,
    output logic [band_w(BANDS)-1:0]    dout_band_o,
    output logic                        dout_error_o,
    output logic                        dout_valid_o,
    output logic                        dout_last_o,
    input  logic                        dout_ready_i,
    output logic [OVF_CNT_WIDTH-1:0]    ovf_count_o,
    output logic                        dup_flag_o
);

    localparam int BAND_W  = band_w(BANDS);
    localparam int ENTRY_W = entry_w(DIN_WIDTH);
    localparam int ADDR_W  = BAND_W + 1;

    logic                     wr_bank_q;
    logic [1:0]               full_q;
    logic [1:0]               full_d;
    logic [BANDS-1:0]         seen_q;
    logic [OVF_CNT_WIDTH-1:0] ovf_q;
    logic                     dup_q;

    logic                     in_range;
    logic                     accept;
    logic                     drop;
    logic                     frame_done;
    logic [BANDS-1:0]         band_oh;
    logic [BANDS-1:0]         seen_next;
    logic [ENTRY_W-1:0]       wdata;

    rd_state_e                state_q;
    logic                     rd_bank_q;
    logic [BAND_W-1:0]        idx_q;
    logic                     dout_valid_q;
    logic                     dout_last_q;
    logic [BAND_W-1:0]        dout_band_q;

    logic                     handshake;
    logic                     last_beat;
    logic                     bank_release;
    logic                     start_frame;
    logic                     rd_en;
    logic [BAND_W-1:0]        rd_idx;
    logic [ENTRY_W-1:0]       rdata;

    // Dominant eigenvector: ties go to the first eigenpair.
    always_comb begin
        if (lamb1_i >= lamb2_i) begin
            wdata = {eigen1_y_i, eigen_x_i, lamb1_i, lamb2_i, din_error_i};
        end else begin
            wdata = {eigen2_y_i, eigen_x_i, lamb2_i, lamb1_i, din_error_i};
        end
    end

    assign in_range = int'(band_in_i) < BANDS;
    assign accept   = din_valid_i && in_range && !full_q[wr_bank_q];
    assign drop     = din_valid_i && !accept;

    always_comb begin
        band_oh = '0;
        if (in_range) begin
            band_oh[band_in_i] = 1'b1;
        end
    end

    assign seen_next  = seen_q | band_oh;
    assign frame_done = accept && (&seen_next);

    // Fill and release always target different banks, so both may land together.
    always_comb begin
        full_d = full_q;
        if (bank_release) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (frame_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            seen_q    <= '0;
            ovf_q     <= '0;
            dup_q     <= 1'b0;
        end else begin
            full_q <= full_d;
            if (accept) begin
                if (seen_q[band_in_i]) begin
                    dup_q <= 1'b1;
                end
                seen_q <= frame_done ? '0 : seen_next;
            end
            if (frame_done) begin
                wr_bank_q <= ~wr_bank_q;
            end
            if (drop && (ovf_q != '1)) begin
                ovf_q <= ovf_q + 1'b1;
            end
        end
    end

    assign handshake    = (state_q == RD_SEND) && dout_ready_i;
    assign last_beat    = int'(idx_q) == BANDS - 1;
    assign bank_release = handshake && last_beat;
    // Looking at the completing write as well lets the first beat appear two cycles after it.
    assign start_frame  = full_q[rd_bank_q] || (frame_done && (wr_bank_q == rd_bank_q));

    always_comb begin
        rd_en  = 1'b0;
        rd_idx = idx_q;
        if (state_q == RD_FETCH) begin
            rd_en = 1'b1;
        end else if (handshake && !last_beat) begin
            rd_en  = 1'b1;
            rd_idx = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RD_IDLE;
            rd_bank_q    <= 1'b0;
            idx_q        <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_band_q  <= '0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (start_frame) begin
                        state_q <= RD_FETCH;
                        idx_q   <= '0;
                    end
                end
                RD_FETCH: begin
                    state_q      <= RD_SEND;
                    dout_valid_q <= 1'b1;
                    dout_band_q  <= idx_q;
                    dout_last_q  <= last_beat;
                end
                RD_SEND: begin
                    if (dout_ready_i) begin
                        if (last_beat) begin
                            state_q      <= RD_IDLE;
                            dout_valid_q <= 1'b0;
                            dout_last_q  <= 1'b0;
                            rd_bank_q    <= ~rd_bank_q;
                        end else begin
                            idx_q       <= idx_q + 1'b1;
                            dout_band_q <= idx_q + 1'b1;
                            dout_last_q <= (int'(idx_q) + 1) == BANDS - 1;
                        end
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    doa_pingpong_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept),
        .waddr_i ({wr_bank_q, band_in_i}),
        .wdata_i (wdata),
        .re_i    (rd_en),
        .raddr_i ({rd_bank_q, rd_idx}),
        .rdata_o (rdata)
    );

    assign {dout_y_o, dout_x_o, dout_lmax_o, dout_lmin_o, dout_error_o} = rdata;
    assign dout_valid_o = dout_valid_q;
    assign dout_last_o  = dout_last_q;
    assign dout_band_o  = dout_band_q;
    assign ovf_count_o  = ovf_q;
    assign dup_flag_o   = dup_q;

endmodule
